// File: rtl/edge_scan_scheduler_pkg.sv
// Shared types for the edge scan scheduler: per-channel history codes
// and the controller state encoding.
package edge_scan_pkg;

    localparam int HIST_W = 2;

    typedef logic [HIST_W-1:0] hist_t;

    // S0: nothing seen yet, S1: last sample 0, S2: last sample 1.
    // Code 2'b11 never gets written and is decoded as S0.
    localparam hist_t S0 = 2'b00;
    localparam hist_t S1 = 2'b01;
    localparam hist_t S2 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } ctrl_t;

endpackage

// File: rtl/edge_scan_scheduler_if.sv
// Tagged edge-event handshake: the scheduler is the master, the consumer the slave.
interface edge_scan_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_ch;
    logic             evt_rise;

    modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);
endinterface

// File: rtl/edge_scan_scheduler_step.sv
// Single-channel transition detector step. Purely combinational; one copy
// is shared by all channels through the scan pointer.
module edge_step
    import edge_scan_pkg::*;
(
    input  hist_t i_hist,
    input  logic  i_a,
    output hist_t o_next,
    output logic  o_edge,
    output logic  o_rise
);

    // The next history only depends on the current sample; the edge
    // depends on whether the stored level differs from it.
    always_comb begin
        o_next = i_a ? S2 : S1;
        o_edge = 1'b0;
        o_rise = 1'b0;
        case (i_hist)
            S1: begin
                if (i_a) begin
                    o_edge = 1'b1;
                    o_rise = 1'b1;
                end
            end
            S2: begin
                if (!i_a) begin
                    o_edge = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/edge_scan_scheduler.sv
// Round-robin edge scanner: one channel is stepped per cycle, detected edges
// are emitted as tagged events on a valid/ready port. A found edge that cannot
// be delivered freezes the scan (HOLD) so it is re-evaluated, never dropped.
// Optional: define EDGE_SCAN_COUNT_EN to add o_evt_count (accepted events, mod 256).
// IDX_W must equal $clog2(N_CH).
module edge_scan_scheduler
    import edge_scan_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [N_CH-1:0]       i_ch_in,
    edge_scan_scheduler_if.master evt,
`ifdef EDGE_SCAN_COUNT_EN
    output logic [7:0]            o_evt_count,
`endif
    output logic                  o_busy
);

    ctrl_t              r_state;
    ctrl_t              w_state_next;
    logic [IDX_W-1:0]   r_ptr;
    hist_t [N_CH-1:0]   w_hist;
    hist_t              w_hist_next;
    logic               w_edge;
    logic               w_rise;
    logic               w_do_step;
    logic               w_load_evt;
    logic               w_accept;
    logic               w_blocked;
    logic               r_evt_valid;
    logic [IDX_W-1:0]   r_evt_ch;
    logic               r_evt_rise;

    assign w_accept  = r_evt_valid && evt.evt_ready;
    assign w_blocked = r_evt_valid && !evt.evt_ready;

    edge_step u_step (
        .i_hist (w_hist[r_ptr]),
        .i_a    (i_ch_in[r_ptr]),
        .o_next (w_hist_next),
        .o_edge (w_edge),
        .o_rise (w_rise)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state plus step/load strobes; clear overrides everything else.
    always_comb begin
        w_state_next = r_state;
        w_do_step    = 1'b0;
        w_load_evt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_en) w_state_next = SCAN;
            end
            SCAN: begin
                if (!i_en) begin
                    w_state_next = IDLE;
                end else if (w_edge && w_blocked) begin
                    w_state_next = HOLD;
                end else begin
                    w_do_step  = 1'b1;
                    w_load_evt = w_edge;
                end
            end
            HOLD: begin
                if (!i_en)           w_state_next = IDLE;
                else if (!w_blocked) w_state_next = SCAN;
            end
            default: w_state_next = IDLE;
        endcase
        if (i_clr) begin
            w_state_next = i_en ? SCAN : IDLE;
            w_do_step    = 1'b0;
            w_load_evt   = 1'b0;
        end
    end

    // Scan pointer: advances only when a step is committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ptr <= '0;
        else if (i_clr)     r_ptr <= '0;
        else if (w_do_step) r_ptr <= (r_ptr == IDX_W'(N_CH - 1)) ? '0 : r_ptr + 1'b1;
    end

    // One history register per channel, written only when it is the scanned one.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        hist_t r_hist;

        // Channel history update.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                    r_hist <= S0;
            else if (i_clr)                                r_hist <= S0;
            else if (w_do_step && r_ptr == IDX_W'(gi))     r_hist <= w_hist_next;
        end

        assign w_hist[gi] = r_hist;
    end

    // Event register: a new event may replace one being accepted this cycle;
    // a blocked event can never be overwritten because that path goes to HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
        end else if (w_load_evt) begin
            r_evt_valid <= 1'b1;
            r_evt_ch    <= r_ptr;
            r_evt_rise  <= w_rise;
        end else if (w_accept) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_ch    = r_evt_ch;
    assign evt.evt_rise  = r_evt_rise;
    assign o_busy        = (r_state != IDLE);

`ifdef EDGE_SCAN_COUNT_EN
    logic [7:0] r_evt_count;

    // Accepted-event counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_evt_count <= 8'd0;
        else if (i_clr)    r_evt_count <= 8'd0;
        else if (w_accept) r_evt_count <= r_evt_count + 8'd1;
    end

    assign o_evt_count = r_evt_count;
`endif

endmodule
